spi_controller: RTL and testbench
=================================

Name: spi_controller

Overview:
- SPI mode-0 controller (initiator) that drives nCS/SCLK/COPI toward the on-chip SPI register peripheral.
- Accepts one write/read request per frame on a valid/ready interface.
- Serialises a 16-bit frame, MSB first: {rw, addr[6:0], data[7:0]}.
- Used by the test harness and by on-chip config sequencing to program the output-enable, PWM-enable and duty-cycle registers.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range >= 2 (elaboration error below 2).
- GAP_CYCLES, 4, minimum clk cycles nCS stays high between frames; legal range >= 4 (elaboration error below 4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE, low while rst high)
- req_write  in  1  frame bit 15 (1 = write)
- req_addr  in  7  register address, frame bits 14:8
- req_data  in  8  payload, frame bits 7:0
- nCS  out  1  chip select, active low, registered
- SCLK  out  1  serial clock, idle low, registered
- COPI  out  1  serial data, registered
- busy  out  1  high from acceptance until return to IDLE
- done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (rst sampled high at posedge clk), next cycle:
  - nCS=1, SCLK=0, COPI=0, busy=0, done=0.
  - State=IDLE, shift register=0, bit/half-period counters=0.
- Acceptance:
  - Handshake occurs at a posedge with req_valid & req_ready.
  - {req_write, req_addr, req_data} latches into a 16-bit shift register.
  - Later changes on the req_* inputs have no effect on the frame in flight.
- States:
  - IDLE: nCS=1, SCLK=0, req_ready=1. On handshake -> SETUP; next cycle nCS=0, COPI=bit15, busy=1.
  - SETUP: CLK_DIV cycles with SCLK=0, then -> HIGH with SCLK=1.
  - HIGH: SCLK=1 for CLK_DIV cycles. At the end:
    - bit_cnt==15 -> HOLD, SCLK=0.
    - otherwise shift left, COPI=next bit, SCLK=0, bit_cnt+1 -> LOW.
  - LOW: SCLK=0 for CLK_DIV cycles, then -> HIGH.
  - HOLD: nCS=0, SCLK=0 for CLK_DIV cycles, then nCS=1, done=1 for one cycle -> GAP.
  - GAP: nCS=1 for GAP_CYCLES cycles, then -> IDLE with busy=0.
- Frame timing:
  - COPI changes only on the cycle SCLK falls, or at acceptance for bit 15. It is stable for CLK_DIV cycles before every SCLK rise.
  - Exactly 16 SCLK rising edges per frame.
  - nCS low for exactly 33*CLK_DIV cycles.
  - Acceptance to done pulse: 33*CLK_DIV+1 cycles.
  - Request-to-request minimum spacing: 33*CLK_DIV+GAP_CYCLES+1 cycles.
- Timing margins for the peripheral:
  - CLK_DIV>=2 guarantees each SCLK level lasts at least 2 cycles, which the peripheral's 2-FF synchroniser plus edge detect needs.
  - GAP_CYCLES>=4 guarantees the peripheral sees the nCS rise and clears its bit count.
- Read frames (req_write=0) are transmitted in full with bit15=0. The peripheral ignores them; the controller has no data return path.
- Addresses above MAX_ADDRESS are transmitted unchanged; rejection is the peripheral's job.
- req_valid while busy: ignored (req_ready=0); the requester holds its request.
- rst mid-frame: next cycle nCS=1, SCLK=0, frame aborted, no done pulse.
  - The peripheral discards the frame because its bit count is not 16.
  - req_ready=1 on the first cycle after rst is released.
- rst and handshake in the same cycle: rst wins, request not accepted.

Decomposition:
- Shared package spi_pkg:
  - FRAME_BITS=16.
  - RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8, DATA_MSB=7.
  - MAX_ADDRESS=7'd4.
  - Register address constants: ADDR_EN_OUT_7_0=0, ADDR_EN_OUT_15_8=1, ADDR_EN_PWM_7_0=2, ADDR_EN_PWM_15_8=3, ADDR_PWM_DUTY=4.
  - Controller state enum {IDLE, SETUP, HIGH, LOW, HOLD, GAP}.
- One sub-module: spi_halfperiod_timer.
  - Down-counter that loads CLK_DIV or GAP_CYCLES and emits an expire pulse.
  - Reused for the SETUP, HIGH, LOW, HOLD and GAP dwell times.

Test Plan:
- Write addr 0x04, data 0x80, CLK_DIV=4 -> COPI sampled at SCLK rises equals 0x8480; 16 rises; nCS low 132 cycles; one done pulse; looped-back peripheral pwm_duty_cycle=0x80.
- Back-to-back writes (0x00<-0xA5, then 0x01<-0x5A) with req_valid held -> second nCS fall at least 4 cycles after first nCS rise; peripheral en_reg_out_7_0=0xA5, en_reg_out_15_8=0x5A.
- Read frame: rw=0, addr 0x02, data 0xFF -> 0x02FF shifted out; all peripheral registers unchanged; done pulses.
- rst asserted after 7th SCLK rise -> next cycle nCS=1, SCLK=0, no done; peripheral registers unchanged; following write to 0x03<-0x3C succeeds.
- req_data changed from 0x11 to 0xEE mid-frame, plus a second req_valid while busy -> frame carries 0x11; req_ready stays 0 until IDLE; second request accepted afterward.
- CLK_DIV=2, write addr 0x05 then addr 0x02<-0x0F -> first frame ignored by peripheral, second sets en_reg_pwm_7_0=0x0F.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants, register map and controller state encoding for the SPI
// initiator and anything that builds frames for it.
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_MSB   = 14;
  localparam int ADDR_LSB   = 8;
  localparam int DATA_MSB   = 7;

  localparam logic [6:0] MAX_ADDRESS      = 7'd4;
  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'd0;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'd1;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'd2;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'd3;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'd4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_state_e;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic       rw,
    input logic [6:0] addr,
    input logic [7:0] data
  );
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_halfperiod_timer.sv
// Dwell-time down-counter: a load starts an N-cycle interval and expire_o
// is high on the last cycle of that interval.
module spi_halfperiod_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load_i) begin
      // Loading N-1 makes the interval exactly N cycles including the last.
      cnt_d = load_val_i - WIDTH'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  assign expire_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one 16-bit {rw, addr, data} frame per request,
// MSB first, with all pin outputs registered.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  output logic       busy,
  output logic       done
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be >= 2");
  end
  if (GAP_CYCLES < 4) begin : g_bad_gap
    $error("spi_controller: GAP_CYCLES must be >= 4");
  end

  localparam int TMR_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  spi_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  ncs_q, ncs_d;
  logic                  sclk_q, sclk_d;
  logic                  copi_q, copi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  tmr_load;
  logic [TMR_W-1:0]      tmr_val;
  logic                  tmr_expire;

  spi_halfperiod_timer #(
    .WIDTH(TMR_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expire_o  (tmr_expire)
  );

  assign req_ready = (state_q == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ncs_q     <= 1'b1;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ncs_q     <= ncs_d;
      sclk_q    <= sclk_d;
      copi_q    <= copi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ncs_d     = ncs_q;
    sclk_d    = sclk_q;
    copi_d    = copi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = TMR_W'(CLK_DIV);

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          shift_d   = build_frame(req_write, req_addr, req_data);
          copi_d    = req_write;
          bit_cnt_d = '0;
          ncs_d     = 1'b0;
          busy_d    = 1'b1;
          tmr_load  = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (tmr_expire) begin
          sclk_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = HIGH;
        end
      end
      HIGH: begin
        if (tmr_expire) begin
          sclk_d   = 1'b0;
          tmr_load = 1'b1;
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
            state_d = HOLD;
          end else begin
            // Next bit goes out on the falling edge, a full half-period before the rise.
            shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
            copi_d    = shift_q[FRAME_BITS-2];
            bit_cnt_d = bit_cnt_q + 4'd1;
            state_d   = LOW;
          end
        end
      end
      LOW: begin
        if (tmr_expire) begin
          sclk_d   = 1'b1;
          tmr_load = 1'b1;
          state_d  = HIGH;
        end
      end
      HOLD: begin
        if (tmr_expire) begin
          ncs_d    = 1'b1;
          done_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GAP_CYCLES);
          state_d  = GAP;
        end
      end
      GAP: begin
        if (tmr_expire) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign nCS  = ncs_q;
  assign SCLK = sclk_q;
  assign COPI = copi_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller at CLK_DIV=4 and CLK_DIV=2, with a
// behavioural register peripheral decoding the serial stream.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid1 = 1'b0;
  logic       valid2 = 1'b0;
  logic       req_write = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       sel = 1'b0;

  logic ready1, ncs1, sclk1, copi1, busy1, done1;
  logic ready2, ncs2, sclk2, copi2, busy2, done2;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(4), .GAP_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(valid1), .req_ready(ready1),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .nCS(ncs1), .SCLK(sclk1), .COPI(copi1), .busy(busy1), .done(done1)
  );

  spi_controller #(.CLK_DIV(2), .GAP_CYCLES(4)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(valid2), .req_ready(ready2),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .nCS(ncs2), .SCLK(sclk2), .COPI(copi2), .busy(busy2), .done(done2)
  );

  logic m_ready, m_ncs, m_sclk, m_copi, m_busy, m_done;
  assign m_ready = sel ? ready2 : ready1;
  assign m_ncs   = sel ? ncs2   : ncs1;
  assign m_sclk  = sel ? sclk2  : sclk1;
  assign m_copi  = sel ? copi2  : copi1;
  assign m_busy  = sel ? busy2  : busy1;
  assign m_done  = sel ? done2  : done1;

  typedef struct {
    logic [15:0] frame;
    int          div;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor / peripheral model state
  logic [15:0] bits = '0;
  int          rises = 0;
  int          low_cnt = 0;
  int          high_cnt = 0;
  int          done_cnt = 0;
  bit          have_rise = 1'b0;
  logic        prev_ncs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [7:0]  per [0:4] = '{default: 8'h00};

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_ncs && !m_ncs) begin
        if (have_rise) check("ncs_gap_ge4", 32'(high_cnt >= 4), 1);
        bits = '0;
        rises = 0;
        low_cnt = 0;
      end
      if (!m_ncs) begin
        low_cnt++;
        if (m_sclk && !prev_sclk) begin
          bits = {bits[14:0], m_copi};
          rises++;
        end
      end else begin
        high_cnt = prev_ncs ? high_cnt + 1 : 1;
      end
      if (!prev_ncs && m_ncs) begin
        have_rise = 1'b1;
        if (rises == 16 && bits[15] && bits[14:8] <= 7'd4)
          per[int'(bits[14:8])] = bits[7:0];
      end
      if (m_busy) check("ready_low_while_busy", 32'(m_ready), 0);
      if (m_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("frame done: frame=%04h expected=%04h rises=%0d ncs_low=%0d latency=%0d",
                   bits, e.frame, rises, low_cnt, cyc - e.acc);
          check("frame_bits", 32'(bits), 32'(e.frame));
          check("sclk_rises", rises, 16);
          check("ncs_low_cycles", low_cnt, 33 * e.div);
          check("accept_to_done", cyc - e.acc, 33 * e.div + 1);
        end
      end
      prev_ncs = m_ncs;
      prev_sclk = m_sclk;
    end
  end

  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d,
                      input logic [15:0] frame, input int div);
    int n = 0;
    @(negedge clk);
    req_write = w;
    req_addr = a;
    req_data = d;
    if (sel) valid2 = 1'b1;
    else valid1 = 1'b1;
    #1;
    while (!m_ready && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!m_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      exp_q.push_back('{frame, div, cyc});
      @(posedge clk);
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((m_busy || exp_q.size() != 0) && n < 5000);
    if (m_busy || exp_q.size() != 0) check("idle_timeout", 0, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dc;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_ncs", 32'(m_ncs), 1);
    check("rst_sclk", 32'(m_sclk), 0);
    check("rst_copi", 32'(m_copi), 0);
    check("rst_busy", 32'(m_busy), 0);
    check("rst_done", 32'(m_done), 0);
    check("rst_ready_low", 32'(m_ready), 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(m_ready), 1);

    // Write 0x04 <- 0x80
    send(1'b1, 7'h04, 8'h80, 16'h8480, 4);
    release_req();
    wait_idle();
    check("pwm_duty_80", 32'(per[4]), 32'h80);

    // Back-to-back writes with req_valid held
    send(1'b1, 7'h00, 8'hA5, 16'h80A5, 4);
    send(1'b1, 7'h01, 8'h5A, 16'h815A, 4);
    release_req();
    wait_idle();
    check("en_out_7_0", 32'(per[0]), 32'hA5);
    check("en_out_15_8", 32'(per[1]), 32'h5A);

    // Read frame leaves registers alone
    send(1'b0, 7'h02, 8'hFF, 16'h02FF, 4);
    release_req();
    wait_idle();
    check("read_keeps_0", 32'(per[0]), 32'hA5);
    check("read_keeps_1", 32'(per[1]), 32'h5A);
    check("read_keeps_2", 32'(per[2]), 32'h00);
    check("read_keeps_3", 32'(per[3]), 32'h00);
    check("read_keeps_4", 32'(per[4]), 32'h80);

    // Abort mid-frame after the 7th SCLK rise
    send(1'b1, 7'h03, 8'h99, 16'h8399, 4);
    n = 0;
    while (rises < 7 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("reached_7_rises", 32'(rises >= 7), 1);
    @(negedge clk);
    rst = 1'b1;
    valid1 = 1'b0;
    void'(exp_q.pop_back());
    dc = done_cnt;
    @(negedge clk);
    #1;
    check("abort_ncs", 32'(m_ncs), 1);
    check("abort_sclk", 32'(m_sclk), 0);
    check("abort_busy", 32'(m_busy), 0);
    check("abort_ready_low", 32'(m_ready), 0);
    rst = 1'b0;
    #1;
    check("abort_ready_after", 32'(m_ready), 1);
    repeat (200) @(negedge clk);
    check("abort_no_done", done_cnt, dc);
    check("abort_reg3_kept", 32'(per[3]), 32'h00);
    send(1'b1, 7'h03, 8'h3C, 16'h833C, 4);
    release_req();
    wait_idle();
    check("en_pwm_15_8", 32'(per[3]), 32'h3C);

    // Data changed mid-frame plus a second request while busy
    send(1'b1, 7'h04, 8'h11, 16'h8411, 4);
    send(1'b1, 7'h04, 8'hEE, 16'h84EE, 4);
    release_req();
    wait_idle();
    check("pwm_duty_ee", 32'(per[4]), 32'hEE);

    // CLK_DIV=2 instance: out-of-range address, then a valid write
    @(negedge clk);
    sel = 1'b1;
    send(1'b1, 7'h05, 8'h12, 16'h8512, 2);
    send(1'b1, 7'h02, 8'h0F, 16'h820F, 2);
    release_req();
    wait_idle();
    check("en_pwm_7_0", 32'(per[2]), 32'h0F);
    check("addr5_no_side_effect", 32'(per[4]), 32'hEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
